// File: rtl/gauss3x3_window_filter_if.sv
// Stream bundle for the 3x3 Gaussian window filter: 3-row column in, filtered pixel out.
// The DUT attaches through the slave modport; the source/sink side uses master.
interface gauss3x3_window_filter_if #(
    parameter int PIXEL_DATA_WIDTH = 16,
    parameter int LINES_NUM        = 3
);
    logic [LINES_NUM*PIXEL_DATA_WIDTH-1:0] s_multiline_pixel_data;
    logic                                  s_pixel_valid;
    logic [PIXEL_DATA_WIDTH-1:0]           m_pixel_data;
    logic                                  m_pixel_valid;
    logic                                  m_line_last;
    logic                                  m_frame_last;

    modport slave (
        input  s_multiline_pixel_data,
        input  s_pixel_valid,
        output m_pixel_data,
        output m_pixel_valid,
        output m_line_last,
        output m_frame_last
    );

    modport master (
        output s_multiline_pixel_data,
        output s_pixel_valid,
        input  m_pixel_data,
        input  m_pixel_valid,
        input  m_line_last,
        input  m_frame_last
    );
endinterface

// File: rtl/gauss3x3_window_filter.sv
// 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1]/16) per RGB565 channel with horizontal edge replication.
// Define GAUSS_ROUND_EN for round-half-up results; otherwise results are truncated.
module gauss3x3_window_filter #(
    parameter int IMAGE_WIDTH      = 1920,
    parameter int IMAGE_HEIGHT     = 1080,
    parameter int PIXEL_DATA_WIDTH = 16,
    parameter int LINES_NUM        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    gauss3x3_window_filter_if.slave bus
);
    localparam int          PW     = PIXEL_DATA_WIDTH;
    localparam int          COL_W  = LINES_NUM * PW;
    localparam logic [10:0] LAST_X = 11'(IMAGE_WIDTH - 1);
    localparam logic [10:0] LAST_Y = 11'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    function automatic logic [6:0] row_sum5(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] c);
        return 7'(a) + {1'b0, b, 1'b0} + 7'(c);
    endfunction

    function automatic logic [7:0] row_sum6(input logic [5:0] a, input logic [5:0] b,
                                            input logic [5:0] c);
        return 8'(a) + {1'b0, b, 1'b0} + 8'(c);
    endfunction

    function automatic logic [8:0] tot_rb(input logic [6:0] t, input logic [6:0] m,
                                          input logic [6:0] b);
        return 9'(t) + {1'b0, m, 1'b0} + 9'(b);
    endfunction

    function automatic logic [9:0] tot_g(input logic [7:0] t, input logic [7:0] m,
                                         input logic [7:0] b);
        return 10'(t) + {1'b0, m, 1'b0} + 10'(b);
    endfunction

    // Max sums (496 / 1008) plus the rounding offset still fit 5 / 6 bits after >>4.
    function automatic logic [4:0] scale_rb(input logic [8:0] s);
`ifdef GAUSS_ROUND_EN
        return 5'((10'(s) + 10'd8) >> 4);
`else
        return 5'(s >> 4);
`endif
    endfunction

    function automatic logic [5:0] scale_g(input logic [9:0] s);
`ifdef GAUSS_ROUND_EN
        return 6'((11'(s) + 11'd8) >> 4);
`else
        return 6'(s >> 4);
`endif
    endfunction

    state_t           state, state_nxt;
    logic [10:0]      hor_cnt, ver_cnt;
    logic [COL_W-1:0] c_cur, c_next;
    logic             accept, col_last;
    logic             load_first, shift;
    logic             win_vld, win_ll, win_fl;
    logic [COL_W-1:0] win_l, win_m, win_r;

    assign accept   = bus.s_pixel_valid;
    assign col_last = (hor_cnt == LAST_X);

    // Window is formed from the registered columns, so a load in the same cycle cannot disturb it.
    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        shift      = 1'b0;
        win_vld    = 1'b0;
        win_ll     = 1'b0;
        win_fl     = 1'b0;
        win_l      = c_cur;
        win_m      = c_next;
        win_r      = bus.s_multiline_pixel_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_first = 1'b1;
                    state_nxt  = FILL;
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    win_vld   = 1'b1;
                    shift     = 1'b1;
                    state_nxt = col_last ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                win_vld = 1'b1;
                win_r   = c_next;
                win_ll  = 1'b1;
                // ver_cnt has already wrapped to 0 once the final line's last column was taken.
                win_fl  = (ver_cnt == 11'd0);
                if (accept) begin
                    load_first = 1'b1;
                    state_nxt  = FILL;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hor_cnt <= 11'd0;
            ver_cnt <= 11'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (col_last) begin
                    hor_cnt <= 11'd0;
                    ver_cnt <= (ver_cnt == LAST_Y) ? 11'd0 : ver_cnt + 11'd1;
                end else begin
                    hor_cnt <= hor_cnt + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_first) begin
            c_cur  <= bus.s_multiline_pixel_data;
            c_next <= bus.s_multiline_pixel_data;
        end else if (shift) begin
            c_cur  <= c_next;
            c_next <= bus.s_multiline_pixel_data;
        end
    end

    // Stage p0: register the nine taps
    logic             vld_p0, ll_p0, fl_p0;
    logic [COL_W-1:0] win_l_p0, win_m_p0, win_r_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            ll_p0  <= 1'b0;
            fl_p0  <= 1'b0;
        end else begin
            vld_p0 <= win_vld;
            ll_p0  <= win_ll;
            fl_p0  <= win_fl;
        end
        if (win_vld) begin
            win_l_p0 <= win_l;
            win_m_p0 <= win_m;
            win_r_p0 <= win_r;
        end
    end

    // Stage p1: horizontal [1 2 1] sum of each row, per channel
    logic       vld_p1, ll_p1, fl_p1;
    logic [6:0] r_row_p1 [LINES_NUM];
    logic [7:0] g_row_p1 [LINES_NUM];
    logic [6:0] b_row_p1 [LINES_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            ll_p1  <= 1'b0;
            fl_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            ll_p1  <= ll_p0;
            fl_p1  <= fl_p0;
        end
        for (int r = 0; r < LINES_NUM; r++) begin
            r_row_p1[r] <= row_sum5(win_l_p0[r*PW+11 +: 5], win_m_p0[r*PW+11 +: 5],
                                    win_r_p0[r*PW+11 +: 5]);
            g_row_p1[r] <= row_sum6(win_l_p0[r*PW+5 +: 6], win_m_p0[r*PW+5 +: 6],
                                    win_r_p0[r*PW+5 +: 6]);
            b_row_p1[r] <= row_sum5(win_l_p0[r*PW +: 5], win_m_p0[r*PW +: 5],
                                    win_r_p0[r*PW +: 5]);
        end
    end

    // Stage p2: vertical [1 2 1] combine and scale by 1/16
    logic          vld_p2, ll_p2, fl_p2;
    logic [PW-1:0] pix_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            ll_p2  <= 1'b0;
            fl_p2  <= 1'b0;
            pix_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            ll_p2  <= ll_p1;
            fl_p2  <= fl_p1;
            if (vld_p1) begin
                pix_p2 <= {scale_rb(tot_rb(r_row_p1[0], r_row_p1[1], r_row_p1[2])),
                           scale_g(tot_g(g_row_p1[0], g_row_p1[1], g_row_p1[2])),
                           scale_rb(tot_rb(b_row_p1[0], b_row_p1[1], b_row_p1[2]))};
            end
        end
    end

    assign bus.m_pixel_data  = pix_p2;
    assign bus.m_pixel_valid = vld_p2;
    assign bus.m_line_last   = ll_p2;
    assign bus.m_frame_last  = fl_p2;
endmodule

// File: tb/tb_gauss3x3_window_filter.sv
// Directed self-checking bench for gauss3x3_window_filter (W=8, H=4).
// Expected values follow the GAUSS_ROUND_EN setting of the build.
module tb_gauss3x3_window_filter;
    localparam int W = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gauss3x3_window_filter_if #(.PIXEL_DATA_WIDTH(16), .LINES_NUM(3)) bus ();

    gauss3x3_window_filter #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_DATA_WIDTH(16), .LINES_NUM(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_data [$];
    logic        q_ll   [$];
    logic        q_fl   [$];
    int          q_cyc  [$];

    always @(negedge clk) begin
        if (bus.m_pixel_valid === 1'b1) begin
            q_data.push_back(bus.m_pixel_data);
            q_ll.push_back(bus.m_line_last);
            q_fl.push_back(bus.m_frame_last);
            q_cyc.push_back(cyc);
        end
    end

    logic [47:0] line_buf [W];
    int          acc_cyc  [W];
    logic [15:0] exp_line [W];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_ll.delete();
        q_fl.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        bus.s_pixel_valid          = 1'b0;
        bus.s_multiline_pixel_data = '0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        step();
        clear_q();
    endtask

    task automatic drive_line(input bit gapped);
        for (int x = 0; x < W; x++) begin
            bus.s_multiline_pixel_data = line_buf[x];
            bus.s_pixel_valid          = 1'b1;
            acc_cyc[x]                 = cyc;
            step();
            if (gapped) begin
                bus.s_pixel_valid = 1'b0;
                step();
            end
        end
    endtask

    task automatic wait_outputs(input int n, output bit timed_out);
        int budget = 300;
        while (q_data.size() < n && budget > 0) begin
            step();
            budget--;
        end
        timed_out = (budget == 0);
        repeat (6) step();
    endtask

    task automatic fill_const(input logic [47:0] v);
        for (int x = 0; x < W; x++) line_buf[x] = v;
    endtask

    task automatic load_mixed();
        fill_const('0);
        line_buf[0] = {16'h001F, 16'h0000, 16'h0000};
        line_buf[3] = {16'h0000, 16'hF800, 16'h0000};
        line_buf[7] = {16'h0000, 16'h0000, 16'h07E0};
`ifdef GAUSS_ROUND_EN
        exp_line = '{16'h0006, 16'h0002, 16'h2000, 16'h4000, 16'h2000, 16'h0000, 16'h0080, 16'h0180};
`else
        exp_line = '{16'h0005, 16'h0001, 16'h1800, 16'h3800, 16'h1800, 16'h0000, 16'h0060, 16'h0160};
`endif
    endtask

    task automatic load_edge();
        fill_const('0);
        line_buf[0] = {16'h001F, 16'h001F, 16'h001F};
`ifdef GAUSS_ROUND_EN
        exp_line = '{16'h0017, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
`else
        exp_line = '{16'h0017, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
`endif
    endtask

    task automatic test_reset();
        bus.s_pixel_valid          = 1'b0;
        bus.s_multiline_pixel_data = '0;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.m_pixel_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.m_pixel_valid);
        end
        checks++;
        if (bus.m_pixel_data !== 16'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0000", bus.m_pixel_data);
        end
        checks++;
        if (bus.m_line_last !== 1'b0) begin
            errors++; $display("FAIL reset_line_last: got %b want 0", bus.m_line_last);
        end
        checks++;
        if (bus.m_frame_last !== 1'b0) begin
            errors++; $display("FAIL reset_frame_last: got %b want 0", bus.m_frame_last);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic check_frame(input string tag);
        bit to;
        wait_outputs(W * H, to);
        checks++;
        if (to || q_data.size() != W * H) begin
            errors++; $display("FAIL %s_count: got %0d want %0d", tag, q_data.size(), W * H);
        end
        for (int i = 0; i < q_data.size() && i < W * H; i++) begin
            checks++;
            if (q_data[i] !== 16'hFFFF || q_ll[i] !== ((i % W) == W - 1) || q_fl[i] !== (i == W * H - 1)) begin
                errors++;
                $display("FAIL %s_pix[%0d]: got data=%h ll=%b fl=%b want data=ffff ll=%b fl=%b",
                         tag, i, q_data[i], q_ll[i], q_fl[i], (i % W) == W - 1, i == W * H - 1);
            end
        end
    endtask

    task automatic test_constant_frame();
        do_reset();
        fill_const(48'hFFFF_FFFF_FFFF);
        for (int y = 0; y < H; y++) drive_line(1'b0);
        idle(1);
        check_frame("const");
    endtask

    task automatic test_line(input string tag, input bit gapped, input int reps);
        bit to;
        do_reset();
        for (int k = 0; k < reps; k++) drive_line(gapped);
        idle(1);
        wait_outputs(W * reps, to);
        checks++;
        if (to || q_data.size() != W * reps) begin
            errors++; $display("FAIL %s_count: got %0d want %0d", tag, q_data.size(), W * reps);
        end
        for (int i = 0; i < q_data.size() && i < W * reps; i++) begin
            checks++;
            if (q_data[i] !== exp_line[i % W] || q_ll[i] !== ((i % W) == W - 1)) begin
                errors++;
                $display("FAIL %s_pix[%0d]: got data=%h ll=%b want data=%h ll=%b",
                         tag, i, q_data[i], q_ll[i], exp_line[i % W], (i % W) == W - 1);
            end
        end
    endtask

    task automatic test_impulse();
        fill_const('0);
        line_buf[3] = {16'h0000, 16'h0800, 16'h0000};
        for (int x = 0; x < W; x++) exp_line[x] = 16'h0000;
        test_line("impulse_r1", 1'b0, 1);
        load_mixed();
        test_line("impulse_mixed", 1'b0, 1);
    endtask

    task automatic test_replication();
        load_edge();
        test_line("replicate", 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        load_edge();
        test_line("b2b_edge", 1'b0, 2);
        load_mixed();
        test_line("b2b_mixed", 1'b0, 3);
    endtask

    task automatic test_gapped();
        int issue;
        load_mixed();
        test_line("gapped", 1'b1, 1);
        for (int i = 0; i < q_cyc.size() && i < W; i++) begin
            issue = (i < W - 1) ? acc_cyc[i + 1] : acc_cyc[W - 1] + 1;
            checks++;
            if (q_cyc[i] != issue + 3) begin
                errors++;
                $display("FAIL gapped_latency[%0d]: got cycle %0d want %0d", i, q_cyc[i], issue + 3);
            end
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        fill_const(48'hFFFF_FFFF_FFFF);
        drive_line(1'b0);
        for (int x = 0; x < 5; x++) begin
            bus.s_multiline_pixel_data = line_buf[x];
            bus.s_pixel_valid          = 1'b1;
            step();
        end
        bus.s_multiline_pixel_data = line_buf[5];
        bus.s_pixel_valid          = 1'b1;
        checks++;
        if (bus.m_pixel_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_active: got valid=%b want 1", bus.m_pixel_valid);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.m_pixel_valid !== 1'b0 || bus.m_pixel_data !== 16'h0 ||
            bus.m_line_last !== 1'b0 || bus.m_frame_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got valid=%b data=%h ll=%b fl=%b want all 0",
                     bus.m_pixel_valid, bus.m_pixel_data, bus.m_line_last, bus.m_frame_last);
        end
        rst = 1'b0;
        idle(2);
        clear_q();
        for (int y = 0; y < H; y++) drive_line(1'b0);
        idle(1);
        check_frame("midrst_frame");
    endtask

    initial begin
        bus.s_pixel_valid          = 1'b0;
        bus.s_multiline_pixel_data = '0;
        test_reset();
        test_constant_frame();
        test_impulse();
        test_replication();
        test_back_to_back();
        test_gapped();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
